// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
package int_sequencer_pkg;

  localparam int PC_W = 10;

  localparam logic [PC_W-1:0] VEC_0      = 10'h3FC;
  localparam logic [PC_W-1:0] VEC_BASE   = 10'h201;
  localparam int              VEC_STRIDE = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    JUMP   = 2'd2,
    RETURN = 2'd3
  } state_e;

  // Line 0 has its own vector; lines 1.. are evenly spaced from the base.
  function automatic logic [PC_W-1:0] vec_addr(input int idx,
                                               input logic [PC_W-1:0] v0,
                                               input logic [PC_W-1:0] base,
                                               input int stride);
    if (idx == 0) return v0;
    return base + PC_W'(stride * (idx - 1));
  endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Core/interrupt-register side signals of the sequencer; slave is the sequencer.
interface int_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import int_sequencer_pkg::*;

  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] irq_pend;
  logic [WIDTH-1:0] irq_act;
  logic             gie;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_data;
  logic             instr_done;
  logic             reti_dec;
  logic [PC_W-1:0]  pc_ret;
  logic             stall;
  logic             pc_load;
  logic [PC_W-1:0]  pc_next;
  logic [WIDTH-1:0] s_calli;
  logic [WIDTH-1:0] s_reti;
  logic [WIDTH-1:0] mask;
  logic [DW-1:0]    depth;
  logic             err_underflow;

  modport slave (
    input  irq_pend, irq_act, gie, cfg_we, cfg_data, instr_done, reti_dec, pc_ret,
    output stall, pc_load, pc_next, s_calli, s_reti, mask, depth, err_underflow
  );

  modport master (
    output irq_pend, irq_act, gie, cfg_we, cfg_data, instr_done, reti_dec, pc_ret,
    input  stall, pc_load, pc_next, s_calli, s_reti, mask, depth, err_underflow
  );

endinterface

// File: rtl/int_sequencer_lsb.sv
// Lowest-set-bit selector: one-hot output, bit 0 wins, zero in gives zero out.
module int_sequencer_lsb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [WIDTH-1:0] out_oh
);

  assign out_oh = in_vec & (~in_vec + WIDTH'(1));

endmodule

// File: rtl/int_sequencer_ret_stack.sv
// Return-address LIFO: synchronous push/pop, combinational top-of-stack read.
module int_sequencer_ret_stack
  import int_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic [DW-1:0]   cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] stk_q [DEPTH];
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            full;

  assign full = (cnt_q == DW'(DEPTH));

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)             cnt_d = cnt_q + DW'(1);
    else if (pop && cnt_q != '0)   cnt_d = cnt_q - DW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) stk_q[AW'(cnt_q)] <= din;
  end

  assign top = (cnt_q != '0) ? stk_q[AW'(cnt_q - DW'(1))] : '0;
  assign cnt = cnt_q;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: picks a pending line, saves the return PC,
// vectors the core, and unwinds on reti.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int              WIDTH      = 8,
  parameter int              DEPTH      = 4,
  parameter logic [PC_W-1:0] VEC_0      = int_sequencer_pkg::VEC_0,
  parameter logic [PC_W-1:0] VEC_BASE   = int_sequencer_pkg::VEC_BASE,
  parameter int              VEC_STRIDE = int_sequencer_pkg::VEC_STRIDE,
  parameter logic [WIDTH-1:0] MASK_RST  = {WIDTH{1'b1}}
) (
  input logic             clk,
  input logic             reset,
  int_sequencer_if.slave  bus
);

  localparam int DW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  logic             pc_load_q, pc_load_d;
  logic [PC_W-1:0]  pc_next_q, pc_next_d;
  logic [WIDTH-1:0] s_calli_q, s_calli_d;
  logic [WIDTH-1:0] s_reti_q, s_reti_d;

  logic [WIDTH-1:0] cand_oh, act_oh;
  logic [PC_W-1:0]  stk_top, vec_sel;
  logic [DW-1:0]    depth;
  logic             push, pop, eligible;

  int_sequencer_lsb #(.WIDTH(WIDTH)) u_cand (
    .in_vec (bus.irq_pend & mask_q & ~bus.irq_act),
    .out_oh (cand_oh)
  );

  // Serves both the active-level compare and the s_reti pulse.
  int_sequencer_lsb #(.WIDTH(WIDTH)) u_act (
    .in_vec (bus.irq_act),
    .out_oh (act_oh)
  );

  int_sequencer_ret_stack #(.DEPTH(DEPTH), .DW(DW)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc_ret),
    .top   (stk_top),
    .cnt   (depth)
  );

  // Both vectors are one-hot, so a lower index is simply a smaller value.
  assign eligible = bus.gie && (depth < DW'(DEPTH)) && (cand_oh != '0) &&
                    ((act_oh == '0) || (cand_oh < act_oh));

  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < WIDTH; i++)
      if (sel_q[i]) vec_sel = vec_addr(i, VEC_0, VEC_BASE, VEC_STRIDE);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    mask_d  = bus.cfg_we ? bus.cfg_data : mask_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_done) begin
          if (bus.reti_dec) begin
            if (depth != '0) state_d = RETURN;
            else             err_d   = 1'b1;
          end else if (eligible) begin
            state_d = SAVE;
            sel_d   = cand_oh;
          end
        end
      end
      SAVE: begin
        push    = 1'b1;
        state_d = JUMP;
      end
      JUMP:    state_d = IDLE;
      RETURN: begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    stall_d   = (state_d != IDLE);
    pc_load_d = (state_d == JUMP) || (state_d == RETURN);
    pc_next_d = (state_d == JUMP)   ? vec_sel :
                (state_d == RETURN) ? stk_top : '0;
    s_calli_d = (state_d == JUMP)   ? sel_q  : '0;
    s_reti_d  = (state_d == RETURN) ? act_oh : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      mask_q    <= MASK_RST;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      pc_load_q <= 1'b0;
      pc_next_q <= '0;
      s_calli_q <= '0;
      s_reti_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
      pc_load_q <= pc_load_d;
      pc_next_q <= pc_next_d;
      s_calli_q <= s_calli_d;
      s_reti_q  <= s_reti_d;
    end
  end

  assign bus.stall         = stall_q;
  assign bus.pc_load       = pc_load_q;
  assign bus.pc_next       = pc_next_q;
  assign bus.s_calli       = s_calli_q;
  assign bus.s_reti        = s_reti_q;
  assign bus.mask          = mask_q;
  assign bus.depth         = depth;
  assign bus.err_underflow = err_q;

endmodule
